// File: rtl/reg_file_dump_pkg.sv
// Shared definitions for the reg_file debug/context-save reader:
// default widths, register count and FSM state encodings.
package reg_file_dump_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 32;
   localparam int REG_COUNT  = 32;

   // Sweep controller states (kept as plain constants for legacy tools)
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_SEND  = 2'd2;

endpackage

// File: rtl/reg_file_dump_if.sv
// Beat stream from the register dump reader to the trace sink:
// valid/ready handshake carrying {addr, data} per beat.
interface reg_file_dump_if
   import reg_file_dump_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;

   // Reader side drives the beat, sink side drives ready
   modport master (output out_valid, output out_addr, output out_data, input out_ready);
   modport slave  (input out_valid, input out_addr, input out_data, output out_ready);

endinterface

// File: rtl/reg_file_dump.sv
// Register file dump reader: walks a (possibly wrapping) address range
// through one reg_file read port and streams {addr, data} beats out,
// one beat per clock when the sink keeps ready high.
module reg_file_dump
   import reg_file_dump_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_rdata,
   reg_file_dump_if.master   out_if,
   output logic              busy,
   output logic              done
);

   logic [1:0]        state_r;
   logic [ADDR_W-1:0] ptr_r;
   logic [ADDR_W-1:0] last_q_r;
   logic              last_flag_r;
   logic              out_valid_r;
   logic [ADDR_W-1:0] out_addr_r;
   logic [DATA_W-1:0] out_data_r;
   logic              done_r;

   logic hs_s;
   logic accept_s;
   logic load_s;
   logic finish_s;

   // Abort outranks both a new start and a pending handshake
   assign hs_s     = out_valid_r & out_if.out_ready;
   assign accept_s = (state_r == ST_IDLE) & start & ~abort;
   assign load_s   = ~abort & ((state_r == ST_FETCH) |
                               ((state_r == ST_SEND) & hs_s & ~last_flag_r));
   assign finish_s = ~abort & (state_r == ST_SEND) & hs_s & last_flag_r;

   // Sweep sequencing: idle -> one fetch cycle -> send until final beat or abort
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE:  state_r <= accept_s ? ST_FETCH : ST_IDLE;
            ST_FETCH: state_r <= abort ? ST_IDLE : ST_SEND;
            ST_SEND:  state_r <= (abort | finish_s) ? ST_IDLE : ST_SEND;
            default:  state_r <= ST_IDLE;
         endcase
      end
   end

   // Address pointer and sweep end: latched on start, pointer advances per loaded beat
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_r    <= {ADDR_W{1'b0}};
         last_q_r <= {ADDR_W{1'b0}};
      end else if (accept_s) begin
         ptr_r    <= first_addr;
         last_q_r <= last_addr;
      end else if (load_s) begin
         ptr_r    <= ptr_r + ADDR_W'(1);
      end
   end

   // Held beat: snapshot of the read port taken at load, stable until handshake
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_addr_r  <= {ADDR_W{1'b0}};
         out_data_r  <= {DATA_W{1'b0}};
         last_flag_r <= 1'b0;
      end else if (load_s) begin
         out_addr_r  <= ptr_r;
         out_data_r  <= rf_rdata;
         last_flag_r <= (ptr_r == last_q_r);
      end
   end

   // Beat valid rises on load, falls after the final handshake or on abort
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_r <= 1'b0;
      end else if (load_s) begin
         out_valid_r <= 1'b1;
      end else if (abort | finish_s) begin
         out_valid_r <= 1'b0;
      end
   end

   // Completion pulse, one cycle after the final beat is accepted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_r <= 1'b0;
      end else begin
         done_r <= finish_s;
      end
   end

   assign rf_addr          = ptr_r;
   assign busy             = (state_r != ST_IDLE);
   assign done             = done_r;
   assign out_if.out_valid = out_valid_r;
   assign out_if.out_addr  = out_addr_r;
   assign out_if.out_data  = out_data_r;

endmodule

// File: tb/tb_reg_file_dump.sv
// Self-checking bench for reg_file_dump: a beat-queue model predicts the
// stream cycle by cycle; directed and random sweeps exercise it.
module tb_reg_file_dump;
   import reg_file_dump_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, abort, we;
   logic [4:0]  first_addr, last_addr, rf_addr, wa;
   logic [31:0] rf_rdata, wd;
   logic        busy, done;
   logic [31:0] regs [32];

   int errors = 0;
   int checks = 0;

   reg_file_dump_if bus ();

   reg_file_dump dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .rf_addr    (rf_addr),
      .rf_rdata   (rf_rdata),
      .out_if     (bus.master),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // reg_file stand-in: combinational read, write on the clock edge
   assign rf_rdata = regs[rf_addr];
   always @(posedge clk) if (we) regs[wa] <= wd;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model + compare ----------------
   logic [4:0]  m_qa [$];
   logic [31:0] m_qd [$];
   logic        m_valid, m_busy, m_done, m_gap;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          m_n;
   logic [4:0]  lq_addr [$];
   logic [31:0] lq_data [$];
   int          vcnt = 0;
   int          dcnt = 0;

   always @(negedge clk) begin
      if (!reset) begin
         m_qa.delete(); m_qd.delete();
         m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_gap = 1'b0;
         chk("rst_valid", bus.out_valid, 1'b0);
         chk("rst_busy", busy, 1'b0);
         chk("rst_done", done, 1'b0);
      end else begin
         chk("valid", bus.out_valid, m_valid);
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         if (m_valid) begin
            chk("beat_addr", bus.out_addr, m_addr);
            chk("beat_data", bus.out_data, m_data);
         end
         if (bus.out_valid && bus.out_ready) begin
            lq_addr.push_back(bus.out_addr);
            lq_data.push_back(bus.out_data);
         end
         if (bus.out_valid) vcnt++;
         if (done) dcnt++;
         // predict the next cycle from the inputs the next edge will sample
         if (m_busy && abort) begin
            m_qa.delete(); m_qd.delete();
            m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_gap = 1'b0;
         end else if (!m_busy) begin
            m_done = 1'b0;
            if (start && !abort) begin
               m_n = ((int'(last_addr) - int'(first_addr) + 32) % 32) + 1;
               for (int k = 0; k < m_n; k++) begin
                  m_qa.push_back(5'((int'(first_addr) + k) % 32));
                  m_qd.push_back(regs[(int'(first_addr) + k) % 32]);
               end
               m_busy = 1'b1;
               m_gap  = 1'b1;
            end
         end else if (m_gap) begin
            m_gap   = 1'b0;
            m_addr  = m_qa.pop_front();
            m_data  = m_qd.pop_front();
            m_valid = 1'b1;
         end else if (m_valid && bus.out_ready) begin
            if (m_qa.size() == 0) begin
               m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b1;
            end else begin
               m_addr = m_qa.pop_front();
               m_data = m_qd.pop_front();
            end
         end else begin
            m_done = 1'b0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_idle();
      int cyc = 0;
      while (busy && cyc < 300) begin
         @(posedge clk); #1; cyc++;
      end
      chk("idle_bound", cyc < 300, 1'b1);
      @(posedge clk); #1;
   endtask

   // mode 0: ready held high, 1: ready toggles, 2: random ready and rare abort
   task automatic run_sweep(input logic [4:0] f, input logic [4:0] l, input int mode);
      int cyc = 0;
      first_addr = f; last_addr = l; bus.out_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      while (busy && cyc < 300) begin
         case (mode)
            1: bus.out_ready = ~bus.out_ready;
            2: begin
               bus.out_ready = (($urandom % 4) != 0);
               abort = (($urandom % 24) == 0);
            end
            default: bus.out_ready = 1'b1;
         endcase
         @(posedge clk); #1; cyc++;
      end
      abort = 1'b0; bus.out_ready = 1'b1;
      chk("sweep_bound", cyc < 300, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      wa = a; wd = d; we = 1'b1;
      @(posedge clk); #1 we = 1'b0;
   endtask

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int base, d0, v0;
      logic [4:0] exp_t2 [4];
      exp_t2 = '{5'd30, 5'd31, 5'd0, 5'd1};
      reset = 1'b0; start = 1'b0; abort = 1'b0; we = 1'b0; wa = 5'd0; wd = 32'd0;
      first_addr = 5'd0; last_addr = 5'd0; bus.out_ready = 1'b0;

      // load the register file while the reader is held in reset
      for (int i = 0; i < 32; i++) begin
         wa = 5'(i);
         case (i)
            0:       wd = 32'd3;
            1:       wd = 32'd5;
            5:       wd = 32'h0000_0555;
            9:       wd = 32'h0000_0909;
            default: wd = $urandom;
         endcase
         we = 1'b1;
         @(posedge clk); #1;
      end
      we = 1'b0;
      chk("reset_rf_addr", rf_addr, 5'd0);
      chk("reset_out_addr", bus.out_addr, 5'd0);
      chk("reset_out_data", bus.out_data, 32'd0);
      chk("reset_out_valid", bus.out_valid, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;

      // two-register sweep
      base = lq_addr.size(); d0 = dcnt; v0 = vcnt;
      run_sweep(5'd0, 5'd1, 0);
      chk("t1_count", lq_addr.size() - base, 2);
      chk("t1_addr0", lq_addr[base], 5'd0);
      chk("t1_data0", lq_data[base], 32'd3);
      chk("t1_addr1", lq_addr[base + 1], 5'd1);
      chk("t1_data1", lq_data[base + 1], 32'd5);
      chk("t1_valid_cycles", vcnt - v0, 2);
      chk("t1_done_once", dcnt - d0, 1);

      // wrapping sweep 30..1
      base = lq_addr.size(); d0 = dcnt;
      run_sweep(5'd30, 5'd1, 0);
      chk("t2_count", lq_addr.size() - base, 4);
      for (int k = 0; k < 4; k++) chk("t2_addr", lq_addr[base + k], exp_t2[k]);
      chk("t2_done_once", dcnt - d0, 1);

      // toggling ready
      base = lq_addr.size();
      run_sweep(5'd2, 5'd4, 1);
      chk("t3_count", lq_addr.size() - base, 3);
      for (int k = 0; k < 3; k++) chk("t3_addr", lq_addr[base + k], 5'(2 + k));

      // snapshot: write reg5 on the edge that loads beat 5
      base = lq_addr.size();
      first_addr = 5'd0; last_addr = 5'd31; bus.out_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 wa = 5'd5; wd = 32'hDEAD; we = 1'b1;
      @(posedge clk); #1 we = 1'b0;
      wait_idle();
      chk("t4_count", lq_addr.size() - base, 32);
      chk("t4_addr5", lq_addr[base + 5], 5'd5);
      chk("t4_old_data5", lq_data[base + 5], 32'h0000_0555);
      base = lq_addr.size();
      run_sweep(5'd0, 5'd31, 0);
      chk("t4_new_data5", lq_data[base + 5], 32'hDEAD);

      // abort in the second SEND cycle
      d0 = dcnt;
      first_addr = 5'd0; last_addr = 5'd7; bus.out_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      chk("t5_abort_valid", bus.out_valid, 1'b0);
      chk("t5_abort_busy", busy, 1'b0);
      @(posedge clk); #1;
      chk("t5_abort_no_done", dcnt - d0, 0);

      // start while busy is ignored
      base = lq_addr.size(); d0 = dcnt;
      first_addr = 5'd0; last_addr = 5'd7; bus.out_ready = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      first_addr = 5'd20; last_addr = 5'd21; start = 1'b1;
      @(posedge clk); #1 start = 1'b0; bus.out_ready = 1'b1;
      wait_idle();
      chk("t5_busy_count", lq_addr.size() - base, 8);
      chk("t5_busy_first", lq_addr[base], 5'd0);
      chk("t5_busy_last", lq_addr[base + 7], 5'd7);
      chk("t5_busy_done", dcnt - d0, 1);
      base = lq_addr.size();
      run_sweep(5'd10, 5'd12, 0);
      chk("t5_after_count", lq_addr.size() - base, 3);
      chk("t5_after_addr", lq_addr[base], 5'd10);

      // random sweeps with random ready, rare aborts, idle-time writes
      for (int r = 0; r < 8; r++) begin
         write_reg(5'($urandom), $urandom);
         run_sweep(5'($urandom), 5'($urandom), 2);
      end

      // asynchronous reset in the middle of a held beat
      d0 = dcnt;
      first_addr = 5'd0; last_addr = 5'd31; bus.out_ready = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("t6_rst_valid", bus.out_valid, 1'b0);
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_done", done, 1'b0);
      chk("t6_rst_addr", bus.out_addr, 5'd0);
      chk("t6_rst_data", bus.out_data, 32'd0);
      chk("t6_rst_rf_addr", rf_addr, 5'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("t6_no_done", dcnt - d0, 0);
      base = lq_addr.size();
      run_sweep(5'd9, 5'd9, 0);
      chk("t6_count", lq_addr.size() - base, 1);
      chk("t6_addr", lq_addr[base], 5'd9);
      chk("t6_data", lq_data[base], 32'h0000_0909);
      chk("t6_done", dcnt - d0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
